// File: rtl/ibuf_write_ctrl.sv
// Purpose : writes DDR beats into NUM_BANKS input-buffer banks, one shared address per beat.
// Latency : 1 cycle from beat acceptance to bank write strobe/address/data.
// Backpres: ddr_ready is high only while a load is in progress; otherwise beats are not taken.
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   start, base_addr,          load command; parameters are latched on start in IDLE
//   num_beats, last_mask
//   ddr_valid/ddr_data/        incoming DDR beat stream (valid/ready handshake)
//   ddr_ready
//   bs_write_req/addr/data     registered per-bank write port
//   busy, done                 load in progress / one-cycle completion pulse
module ibuf_write_ctrl #(
  parameter int DDR_BANDWIDTH    = 512,
  parameter int NUM_BANKS        = 64,
  parameter int WRITE_ADDR_WIDTH = 8,
  parameter int COUNT_WIDTH      = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [WRITE_ADDR_WIDTH-1:0]           base_addr,
  input  logic [COUNT_WIDTH-1:0]                num_beats,
  input  logic [NUM_BANKS-1:0]                  last_mask,
  input  logic                                  ddr_valid,
  input  logic [DDR_BANDWIDTH-1:0]              ddr_data,
  output logic                                  ddr_ready,
  output logic [NUM_BANKS-1:0]                  bs_write_req,
  output logic [NUM_BANKS*WRITE_ADDR_WIDTH-1:0] bs_write_addr,
  output logic [DDR_BANDWIDTH-1:0]              bs_write_data,
  output logic                                  busy,
  output logic                                  done
);

  localparam int WRITE_WIDTH = DDR_BANDWIDTH / NUM_BANKS;

  // Each bank receives an equal slice of the beat; reject uneven splits at elaboration.
  generate
    if (WRITE_WIDTH * NUM_BANKS != DDR_BANDWIDTH) begin : g_bad_split
      $error("DDR_BANDWIDTH must be an exact multiple of NUM_BANKS");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                        state;
  logic [WRITE_ADDR_WIDTH-1:0]   base_q;
  logic [COUNT_WIDTH-1:0]        beats_q;
  logic [NUM_BANKS-1:0]          mask_q;
  logic [COUNT_WIDTH-1:0]        beat_cnt;

  logic                          accept;
  logic                          last_beat;
  logic [WRITE_ADDR_WIDTH-1:0]   cur_addr;

  // ddr_ready is only ever high in LOAD, so this is the sole acceptance condition.
  assign accept    = ddr_valid && ddr_ready;
  assign last_beat = (beat_cnt == beats_q - COUNT_WIDTH'(1));
  // Address wraps modulo 2^WRITE_ADDR_WIDTH by truncation.
  assign cur_addr  = base_q + WRITE_ADDR_WIDTH'(beat_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      base_q        <= '0;
      beats_q       <= '0;
      mask_q        <= '0;
      beat_cnt      <= '0;
      ddr_ready     <= 1'b0;
      bs_write_req  <= '0;
      bs_write_addr <= '0;
      bs_write_data <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      // Strobe and done are single-cycle unless re-asserted below.
      bs_write_req <= '0;
      done         <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            beats_q  <= num_beats;
            mask_q   <= last_mask;
            beat_cnt <= '0;
            busy     <= 1'b1;
            if (num_beats != '0) begin
              state     <= LOAD;
              ddr_ready <= 1'b1;
            end else begin
              // Empty load: pass straight through DONE with no writes.
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (accept) begin
            bs_write_data <= ddr_data;
            bs_write_addr <= {NUM_BANKS{cur_addr}};
            beat_cnt      <= beat_cnt + COUNT_WIDTH'(1);
            if (last_beat) begin
              // Final strobe and done land in the same cycle.
              bs_write_req <= mask_q;
              state        <= DONE;
              done         <= 1'b1;
              ddr_ready    <= 1'b0;
            end else begin
              bs_write_req <= '1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          ddr_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ibuf_write_ctrl.sv
// Purpose : directed self-checking bench for ibuf_write_ctrl with default parameters.
// Latency : outputs checked on the falling edge, one cycle after each accepted beat.
// Backpres: ddr_valid patterns include gaps; beats offered while not ready must be ignored.
module tb_ibuf_write_ctrl;

  localparam int DW = 512;
  localparam int NB = 64;
  localparam int AW = 8;
  localparam int CW = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [AW-1:0]    base_addr = '0;
  logic [CW-1:0]    num_beats = '0;
  logic [NB-1:0]    last_mask = '0;
  logic             ddr_valid = 1'b0;
  logic [DW-1:0]    ddr_data = '0;
  logic             ddr_ready;
  logic [NB-1:0]    bs_write_req;
  logic [NB*AW-1:0] bs_write_addr;
  logic [DW-1:0]    bs_write_data;
  logic             busy;
  logic             done;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] last_data = '0;

  ibuf_write_ctrl #(
    .DDR_BANDWIDTH   (DW),
    .NUM_BANKS       (NB),
    .WRITE_ADDR_WIDTH(AW),
    .COUNT_WIDTH     (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .num_beats    (num_beats),
    .last_mask    (last_mask),
    .ddr_valid    (ddr_valid),
    .ddr_data     (ddr_data),
    .ddr_ready    (ddr_ready),
    .bs_write_req (bs_write_req),
    .bs_write_addr(bs_write_addr),
    .bs_write_data(bs_write_data),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input logic [7:0] base, input int k);
    logic [31:0] w;
    w = {8'hC3, base, 16'(k)};
    return {16{w}};
  endfunction

  // Issues one load and checks every cycle until the cycle after done.
  // vpat bit i is ddr_valid in the i-th cycle after the start edge.
  task automatic run_load(input string tag, input logic [7:0] base, input logic [15:0] nb,
                          input logic [63:0] mask, input logic [31:0] vpat, input bit extra_start);
    int            accepted;
    bit            pend;
    bit            pend_last;
    bit            ready_exp;
    bit            finished;
    logic [7:0]    pend_addr;
    logic [DW-1:0] exp_req;
    accepted  = 0;
    pend      = 1'b0;
    pend_last = 1'b0;
    finished  = 1'b0;
    pend_addr = '0;

    // Valid offered in the start cycle while not ready: must not be captured.
    start     = 1'b1;
    base_addr = base;
    num_beats = nb;
    last_mask = mask;
    ddr_valid = 1'b1;
    ddr_data  = {DW{1'b1}};
    @(negedge clk);
    start     = 1'b0;
    ddr_valid = 1'b0;

    if (nb == 16'd0) begin
      chk({tag, ".done"},  done, 1);
      chk({tag, ".busy"},  busy, 1);
      chk({tag, ".ready"}, ddr_ready, 0);
      chk({tag, ".req"},   bs_write_req, 0);
      ddr_valid = 1'b1;
      @(negedge clk);
      chk({tag, ".done_end"},  done, 0);
      chk({tag, ".busy_end"},  busy, 0);
      chk({tag, ".ready_end"}, ddr_ready, 0);
      chk({tag, ".req_end"},   bs_write_req, 0);
      ddr_valid = 1'b0;
      return;
    end

    ready_exp = 1'b1;
    for (int cyc = 0; cyc < 32 && !finished; cyc++) begin
      exp_req = '0;
      if (pend) exp_req[NB-1:0] = pend_last ? mask : {NB{1'b1}};
      chk({tag, ".ready"}, ddr_ready, ready_exp);
      chk({tag, ".busy"},  busy, 1);
      chk({tag, ".done"},  done, pend && pend_last);
      chk({tag, ".req"},   bs_write_req, exp_req);
      chk({tag, ".data"},  bs_write_data, last_data);
      if (pend) chk({tag, ".addr"}, bs_write_addr, {NB{pend_addr}});

      if (pend && pend_last) begin
        finished  = 1'b1;
        ddr_valid = 1'b0;
        start     = 1'b0;
      end else begin
        ddr_valid = vpat[cyc];
        ddr_data  = beat_data(base, accepted);
        start     = extra_start && (cyc == 1);
        if (start) begin
          base_addr = 8'h55;
          num_beats = 16'd7;
          last_mask = '0;
        end
        pend = ddr_valid && ready_exp;
        if (pend) begin
          pend_addr = base + 8'(accepted);
          last_data = ddr_data;
          pend_last = (accepted == int'(nb) - 1);
          accepted++;
          if (pend_last) ready_exp = 1'b0;
        end
      end
      @(negedge clk);
    end

    if (!finished) begin
      chk({tag, ".timeout"}, 0, 1);
    end else begin
      // First IDLE cycle; the next load starts right here.
      chk({tag, ".busy_end"},  busy, 0);
      chk({tag, ".done_end"},  done, 0);
      chk({tag, ".req_end"},   bs_write_req, 0);
      chk({tag, ".ready_end"}, ddr_ready, 0);
    end
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst.req",   bs_write_req, 0);
    chk("rst.addr",  bs_write_addr, 0);
    chk("rst.data",  bs_write_data, 0);
    chk("rst.ready", ddr_ready, 0);
    chk("rst.busy",  busy, 0);
    chk("rst.done",  done, 0);
    reset = 1'b0;
    @(negedge clk);

    run_load("seq4",  8'h10, 16'd4, {64{1'b1}}, 32'hFFFF_FFFF, 1'b0);
    run_load("gap3",  8'h40, 16'd3, {64{1'b1}}, 32'h0000_0015, 1'b0);
    run_load("wrap",  8'hFE, 16'd4, {64{1'b1}}, 32'hFFFF_FFFF, 1'b0);
    run_load("zero",  8'h33, 16'd0, {64{1'b1}}, 32'hFFFF_FFFF, 1'b0);
    run_load("mask",  8'h00, 16'd2, 64'h0000_0000_0000_00FF, 32'hFFFF_FFFF, 1'b1);
    run_load("gap5",  8'h80, 16'd5, 64'h8000_0000_0000_0001, 32'hFFFF_FF36, 1'b0);

    // Reset mid-load after two of five beats
    start     = 1'b1;
    base_addr = 8'h20;
    num_beats = 16'd5;
    last_mask = {64{1'b1}};
    ddr_valid = 1'b1;
    ddr_data  = beat_data(8'h20, 0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort.req0", bs_write_req, {NB{1'b1}});
    ddr_data = beat_data(8'h20, 1);
    @(negedge clk);
    chk("abort.req1",  bs_write_req, {NB{1'b1}});
    chk("abort.addr1", bs_write_addr, {NB{8'h21}});
    #2 reset = 1'b1;
    #1;
    chk("abort.req",   bs_write_req, 0);
    chk("abort.addr",  bs_write_addr, 0);
    chk("abort.data",  bs_write_data, 0);
    chk("abort.ready", ddr_ready, 0);
    chk("abort.busy",  busy, 0);
    chk("abort.done",  done, 0);
    @(negedge clk);
    reset     = 1'b0;
    last_data = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post.req",   bs_write_req, 0);
      chk("post.busy",  busy, 0);
      chk("post.ready", ddr_ready, 0);
      chk("post.data",  bs_write_data, 0);
    end
    ddr_valid = 1'b0;
    run_load("clean", 8'h70, 16'd3, {64{1'b1}}, 32'hFFFF_FFFF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
